// File: rtl/fetch_line_buffer_if.sv
// Fetch-side request/response bundle for fetch_line_buffer.
// master = fetch stage (requester), slave = line buffer (responder).
interface fetch_line_buffer_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, CacheHit, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, CacheHit, err
  );
endinterface

// File: rtl/fetch_line_buffer.sv
// Single 4-word instruction line buffer; refills word 0..3 from backing memory.
// Optional LB_PERF_CNT_EN adds saturating hit/miss counters and createdump print.
module fetch_line_buffer #(
  parameter int LINE_WORDS   = 4,
  parameter bit ERR_ON_WRITE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_line_buffer_if.slave   bus,
  output logic                 mem_rd,
  output logic [15:0]          mem_addr,
  input  logic [15:0]          mem_data,
  input  logic                 mem_valid
`ifdef LB_PERF_CNT_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [12:0] r_tag;
  logic [1:0]  r_off;
  logic [1:0]  r_cnt;
  logic        r_valid;
  logic [15:0] r_line [LINE_WORDS];

  logic w_legal;
  logic w_illegal;
  logic w_hit;
  logic w_miss_evt;
  logic w_hit_evt;
  logic w_last;

  assign w_legal   = bus.Rd & ~bus.Wr & ~bus.Addr[0];
  assign w_illegal = (bus.Rd & bus.Wr) | (bus.Rd & bus.Addr[0]) |
                     (bus.Wr & ERR_ON_WRITE);
  assign w_hit     = w_legal & r_valid & (r_tag == bus.Addr[15:3]);
  assign w_hit_evt  = (r_state == IDLE) & w_hit;
  assign w_miss_evt = (r_state == IDLE) & w_legal & ~w_hit;
  assign w_last     = (r_cnt == 2'(LINE_WORDS - 1));

  always_comb begin
    w_next       = r_state;
    bus.DataOut  = 16'h0000;
    bus.Done     = 1'b0;
    bus.Stall    = 1'b0;
    bus.CacheHit = 1'b0;
    bus.err      = 1'b0;
    mem_rd       = 1'b0;
    mem_addr     = 16'h0000;
    unique case (r_state)
      IDLE: begin
        if (w_illegal) begin
          bus.err = 1'b1;
        end else if (w_hit) begin
          bus.DataOut  = r_line[bus.Addr[2:1]];
          bus.Done     = 1'b1;
          bus.CacheHit = 1'b1;
        end else if (w_legal) begin
          bus.Stall = 1'b1;
          w_next    = REQ;
        end
      end
      REQ: begin
        mem_rd    = 1'b1;
        mem_addr  = {r_tag, r_cnt, 1'b0};
        bus.Stall = 1'b1;
        w_next    = WAIT;
      end
      WAIT: begin
        mem_addr  = {r_tag, r_cnt, 1'b0};
        bus.Stall = 1'b1;
        if (mem_valid) begin
          w_next = w_last ? RESP : REQ;
        end
      end
      RESP: begin
        bus.DataOut = r_line[r_off];
        bus.Done    = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag   <= '0;
      r_off   <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_miss_evt) begin
        r_tag   <= bus.Addr[15:3];
        r_off   <= bus.Addr[2:1];
        r_cnt   <= '0;
        r_valid <= 1'b0;
      end
      if (r_state == WAIT && mem_valid) begin
        if (w_last) r_valid <= 1'b1;
        else        r_cnt   <= r_cnt + 2'd1;
      end
    end
  end

  // Line storage needs no reset; r_valid guards every read.
  always_ff @(posedge clk) begin
    if (!rst && r_state == WAIT && mem_valid) begin
      r_line[r_cnt] <= mem_data;
    end
  end

`ifdef LB_PERF_CNT_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;
  logic        w_unused;

  assign w_unused   = ^bus.DataIn;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit_evt && r_hit_cnt != 16'hFFFF) begin
        r_hit_cnt <= r_hit_cnt + 16'd1;
      end
      if (w_miss_evt && r_miss_cnt != 16'hFFFF) begin
        r_miss_cnt <= r_miss_cnt + 16'd1;
      end
      if (bus.createdump) begin
        $display("line buffer: hits=%0d misses=%0d",
                 r_hit_cnt, r_miss_cnt);
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{bus.DataIn, bus.createdump, w_hit_evt};
`endif

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Directed bench for fetch_line_buffer with a latency-2 backing memory.
// Second instance uses ERR_ON_WRITE=1 to check write rejection.
module tb_fetch_line_buffer;
  logic        clk;
  logic        rst;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        mem_rd_w;
  logic [15:0] mem_addr_w;
  logic [15:0] mem_data_w;
  logic        mem_valid_w;
`ifdef LB_PERF_CNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [15:0] hit_count_w;
  logic [15:0] miss_count_w;
`endif

  fetch_line_buffer_if bus ();
  fetch_line_buffer_if bus_w ();

  fetch_line_buffer #(.ERR_ON_WRITE(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid)
`ifdef LB_PERF_CNT_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  fetch_line_buffer #(.ERR_ON_WRITE(1'b1)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_w.slave),
    .mem_rd    (mem_rd_w),
    .mem_addr  (mem_addr_w),
    .mem_data  (mem_data_w),
    .mem_valid (mem_valid_w)
`ifdef LB_PERF_CNT_EN
    ,
    .hit_count (hit_count_w),
    .miss_count(miss_count_w)
`endif
  );

  localparam int L = 2;

  logic [15:0] mem [32];
  logic [15:0] rd_log [$];
  int          pend;
  logic [4:0]  paddr;
  int          n_cmp;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: mem_valid arrives L cycles after the mem_rd cycle.
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        mem_valid = 1'b1;
        mem_data  = mem[paddr];
      end
    end
    if (mem_rd === 1'b1) begin
      pend  = L;
      paddr = mem_addr[5:1];
      rd_log.push_back(mem_addr);
    end
  end

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk); #1;
      if (bus.Done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Done, bus.Stall, bus.CacheHit, bus.err, mem_rd} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.Done, bus.Stall, bus.CacheHit, bus.err, mem_rd});
    end
    n_cmp++;
    if ({bus.DataOut, mem_addr} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h want 0",
               {bus.DataOut, mem_addr});
    end
  endtask

  task automatic test_miss_fill;
    int bad;
    bad = 0;
    rd_log.delete();
    @(negedge clk);
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0010;
    #1;
    n_cmp++;
    if ({bus.Stall, bus.Done} !== 2'b10) begin
      n_fail++;
      $display("FAIL miss_stall got %b want 10", {bus.Stall, bus.Done});
    end
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      if (bus.Stall !== 1'b1 || bus.Done !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL fill_stall bad_cycles got %0d want 0", bad);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.Done, bus.CacheHit, bus.Stall, bus.DataOut} !==
        {3'b100, 16'hA000}) begin
      n_fail++;
      $display("FAIL miss_resp got %b%b%b %h want 100 a000",
               bus.Done, bus.CacheHit, bus.Stall, bus.DataOut);
    end
    n_cmp++;
    if (rd_log.size() !== 4) begin
      n_fail++;
      $display("FAIL fill_pulses got %0d want 4", rd_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rd_log[i] !== 16'h0010 + 16'(2 * i)) begin
          n_fail++;
          $display("FAIL fill_addr%0d got %h want %h", i, rd_log[i],
                   16'h0010 + 16'(2 * i));
        end
      end
    end
  endtask

  task automatic test_hit;
    @(negedge clk);
    bus.Addr = 16'h0014;
    #1;
    n_cmp++;
    if ({bus.Done, bus.CacheHit, bus.Stall, mem_rd, bus.DataOut} !==
        {4'b1100, 16'hA002}) begin
      n_fail++;
      $display("FAIL hit_0x14 got %b%b%b%b %h want 1100 a002",
               bus.Done, bus.CacheHit, bus.Stall, mem_rd, bus.DataOut);
    end
    @(negedge clk);
    bus.Addr = 16'h0016;
    #1;
    n_cmp++;
    if ({bus.Done, bus.CacheHit, bus.DataOut} !== {2'b11, 16'hA003}) begin
      n_fail++;
      $display("FAIL hit_0x16 got %b%b %h want 11 a003",
               bus.Done, bus.CacheHit, bus.DataOut);
    end
    bus.Rd = 1'b0;
  endtask

  task automatic test_replace;
    int lat;
    rd_log.delete();
    @(negedge clk);
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0018;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b1) begin
      n_fail++;
      $display("FAIL replace_miss stall got %b want 1", bus.Stall);
    end
    @(negedge clk);
    bus.Addr = 16'h0000;
    wait_done(lat);
    n_cmp++;
    if (lat + 1 !== 13) begin
      n_fail++;
      $display("FAIL replace_latency got %0d want 13", lat + 1);
    end
    n_cmp++;
    if ({bus.CacheHit, bus.DataOut} !== {1'b0, 16'hB000}) begin
      n_fail++;
      $display("FAIL replace_resp got %b %h want 0 b000",
               bus.CacheHit, bus.DataOut);
    end
    n_cmp++;
    if (rd_log.size() !== 4 || rd_log[3] !== 16'h001E) begin
      n_fail++;
      $display("FAIL replace_pulses got %0d want 4 ending 001e",
               rd_log.size());
    end
    bus.Rd = 1'b0;
    @(negedge clk);
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0010;
    #1;
    n_cmp++;
    if ({bus.Stall, bus.Done} !== 2'b10) begin
      n_fail++;
      $display("FAIL old_line_miss got %b want 10", {bus.Stall, bus.Done});
    end
    wait_done(lat);
    n_cmp++;
    if (lat !== 13 || bus.DataOut !== 16'hA000) begin
      n_fail++;
      $display("FAIL refill_0x10 got lat %0d %h want 13 a000",
               lat, bus.DataOut);
    end
    bus.Rd = 1'b0;
  endtask

  task automatic test_illegal;
    @(negedge clk);
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0011;
    #1;
    n_cmp++;
    if ({bus.err, bus.Done, bus.Stall, mem_rd} !== 4'b1000) begin
      n_fail++;
      $display("FAIL odd_addr got %b want 1000",
               {bus.err, bus.Done, bus.Stall, mem_rd});
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.Stall, mem_rd} !== 2'b00) begin
      n_fail++;
      $display("FAIL odd_addr_idle got %b want 00", {bus.Stall, mem_rd});
    end
    @(negedge clk);
    bus.Addr = 16'h0010;
    bus.Wr   = 1'b1;
    #1;
    n_cmp++;
    if ({bus.err, bus.Done, bus.Stall} !== 3'b100) begin
      n_fail++;
      $display("FAIL rd_wr got %b want 100",
               {bus.err, bus.Done, bus.Stall});
    end
    @(negedge clk);
    bus.Rd   = 1'b0;
    bus_w.Wr = 1'b1;
    #1;
    n_cmp++;
    if ({bus.err, bus.Done, bus.Stall, mem_rd} !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_ignored got %b want 0000",
               {bus.err, bus.Done, bus.Stall, mem_rd});
    end
    n_cmp++;
    if ({bus_w.err, bus_w.Stall} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_err got %b want 10", {bus_w.err, bus_w.Stall});
    end
    @(negedge clk);
    bus.Wr   = 1'b0;
    bus_w.Wr = 1'b0;
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0012;
    #1;
    n_cmp++;
    if ({bus.Done, bus.CacheHit, bus.DataOut} !== {2'b11, 16'hA001}) begin
      n_fail++;
      $display("FAIL hit_after_err got %b%b %h want 11 a001",
               bus.Done, bus.CacheHit, bus.DataOut);
    end
    bus.Rd = 1'b0;
  endtask

  task automatic test_reset_mid_fill;
    int lat;
    rd_log.delete();
    @(negedge clk);
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0018;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (rd_log.size() >= 3) break;
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.Stall, mem_addr} !== {1'b1, 16'h001C}) begin
      n_fail++;
      $display("FAIL wait_word2 got %b %h want 1 001c",
               bus.Stall, mem_addr);
    end
    rst    = 1'b1;
    bus.Rd = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.Done, bus.Stall, bus.CacheHit, bus.err, mem_rd,
         bus.DataOut, mem_addr} !== 37'h0) begin
      n_fail++;
      $display("FAIL post_rst got %b%b%b%b%b %h %h want all 0",
               bus.Done, bus.Stall, bus.CacheHit, bus.err, mem_rd,
               bus.DataOut, mem_addr);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.Done, bus.Stall, mem_rd} !== 3'b000) begin
      n_fail++;
      $display("FAIL late_valid got %b want 000",
               {bus.Done, bus.Stall, mem_rd});
    end
    repeat (2) @(negedge clk);
    rd_log.delete();
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0018;
    #1;
    n_cmp++;
    if ({bus.Stall, bus.CacheHit} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_remiss got %b want 10", {bus.Stall, bus.CacheHit});
    end
    wait_done(lat);
    n_cmp++;
    if (lat !== 13 || rd_log.size() !== 4 || bus.DataOut !== 16'hB000) begin
      n_fail++;
      $display("FAIL rst_refill got lat %0d pulses %0d %h want 13 4 b000",
               lat, rd_log.size(), bus.DataOut);
    end
    bus.Rd = 1'b0;
  endtask

`ifdef LB_PERF_CNT_EN
  task automatic test_perf;
    int lat;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0010;
    wait_done(lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.Addr = 16'h0010 + 16'(2 * i);
    end
    @(negedge clk);
    bus.Rd         = 1'b0;
    bus.createdump = 1'b1;
    #1;
    n_cmp++;
    if ({miss_count, hit_count} !== {16'd1, 16'd3}) begin
      n_fail++;
      $display("FAIL perf got miss %0d hit %0d want 1 3",
               miss_count, hit_count);
    end
    @(negedge clk);
    bus.createdump = 1'b0;
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    pend   = 0;
    paddr  = '0;
    mem_valid   = 1'b0;
    mem_data    = 16'h0;
    mem_data_w  = 16'h0;
    mem_valid_w = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    for (int i = 0; i < 4; i++) begin
      mem[8 + i]  = 16'hA000 + 16'(i);
      mem[12 + i] = 16'hB000 + 16'(i);
    end
    bus.Addr         = 16'h0;
    bus.DataIn       = 16'h0;
    bus.Rd           = 1'b0;
    bus.Wr           = 1'b0;
    bus.createdump   = 1'b0;
    bus_w.Addr       = 16'h0;
    bus_w.DataIn     = 16'h0;
    bus_w.Rd         = 1'b0;
    bus_w.Wr         = 1'b0;
    bus_w.createdump = 1'b0;
    test_reset();
    test_miss_fill();
    test_hit();
    test_replace();
    test_illegal();
    test_reset_mid_fill();
`ifdef LB_PERF_CNT_EN
    test_perf();
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
